// File: rtl/spi_pixel_slave.sv
// Framed SPI receiver: command byte, 16-bit start address, then auto-incrementing pixel writes.
// Define SPI_STATUS_READBACK_EN to shift frame_count out on spi_miso during the command byte.
module spi_pixel_slave #(
  parameter  int BITS_PER_PIXEL = 32,
  parameter  int PIXEL_COUNT    = 2048,
  localparam int ADDR_BITS      = $clog2(PIXEL_COUNT)
) (
  input  logic                      spi_clk,
  input  logic                      reset,
  input  logic                      spi_ss_n,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic [BITS_PER_PIXEL-1:0] data,
  output logic [ADDR_BITS-1:0]      addr,
  output logic                      pixel_clk,
  output logic                      flip
);

  // The shifter must hold either a full pixel word or the 16-bit address field.
  localparam int SHIFT_W = (BITS_PER_PIXEL > 16) ? BITS_PER_PIXEL : 16;
  localparam int CNT_W   = $clog2(SHIFT_W);

  localparam logic [16:0]          PIXEL_COUNT_17 = 17'(PIXEL_COUNT);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR      = ADDR_BITS'(PIXEL_COUNT - 1);
  localparam logic [CNT_W-1:0]     LAST_CMD_BIT   = CNT_W'(7);
  localparam logic [CNT_W-1:0]     LAST_ADDR_BIT  = CNT_W'(15);
  localparam logic [CNT_W-1:0]     LAST_PIX_BIT   = CNT_W'(BITS_PER_PIXEL - 1);

  typedef enum logic [1:0] {
    S_CMD,
    S_ADDR,
    S_PIXELS,
    S_DISCARD
  } state_t;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_bit_cnt;
  logic [SHIFT_W-2:0]        r_shift;
  logic [ADDR_BITS-1:0]      r_next_addr;
  logic [BITS_PER_PIXEL-1:0] r_data;
  logic [ADDR_BITS-1:0]      r_addr;
  logic                      r_pixel_clk;
  logic                      r_flip;

  logic [SHIFT_W-1:0]        w_shift_next;
  logic [15:0]               w_addr16;

  assign w_shift_next = {r_shift, spi_mosi};
  assign w_addr16     = w_shift_next[15:0];

  assign data      = r_data;
  assign addr      = r_addr;
  assign pixel_clk = r_pixel_clk;
  assign flip      = r_flip;

`ifdef SPI_STATUS_READBACK_EN
  logic [7:0] r_frame_count;
  logic       r_miso;
  assign spi_miso = r_miso;
`else
  assign spi_miso = 1'b0;
`endif

  // NOTE: all state is updated with non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_CMD;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_next_addr <= '0;
      r_data      <= '0;
      r_addr      <= '0;
      r_pixel_clk <= 1'b0;
      r_flip      <= 1'b0;
`ifdef SPI_STATUS_READBACK_EN
      r_frame_count <= '0;
      r_miso        <= 1'b0;
`endif
    end else if (spi_ss_n) begin
      // Deselect wins over any word completing on this edge.
      r_state     <= S_CMD;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_pixel_clk <= 1'b0;
      r_flip      <= 1'b0;
`ifdef SPI_STATUS_READBACK_EN
      r_miso      <= 1'b0;
`endif
    end else begin
      r_pixel_clk <= 1'b0;
      r_flip      <= 1'b0;
      r_shift     <= w_shift_next[SHIFT_W-2:0];
      r_bit_cnt   <= r_bit_cnt + 1'b1;
`ifdef SPI_STATUS_READBACK_EN
      r_miso      <= 1'b0;
`endif
      case (r_state)
        S_CMD: begin
`ifdef SPI_STATUS_READBACK_EN
          r_miso <= r_frame_count[3'd7 - r_bit_cnt[2:0]];
`endif
          if (r_bit_cnt == LAST_CMD_BIT) begin
            r_bit_cnt <= '0;
            if (w_shift_next[7:0] == 8'h01) begin
              r_state <= S_ADDR;
            end else begin
              if (w_shift_next[7:0] == 8'h02) begin
                r_flip <= 1'b1;
`ifdef SPI_STATUS_READBACK_EN
                r_frame_count <= r_frame_count + 8'd1;
`endif
              end
              r_state <= S_DISCARD;
            end
          end
        end
        S_ADDR: begin
          if (r_bit_cnt == LAST_ADDR_BIT) begin
            r_bit_cnt   <= '0;
            r_state     <= S_PIXELS;
            r_next_addr <= ({1'b0, w_addr16} >= PIXEL_COUNT_17) ? '0 : w_addr16[ADDR_BITS-1:0];
          end
        end
        S_PIXELS: begin
          if (r_bit_cnt == LAST_PIX_BIT) begin
            r_bit_cnt   <= '0;
            r_data      <= w_shift_next[BITS_PER_PIXEL-1:0];
            r_addr      <= r_next_addr;
            r_pixel_clk <= 1'b1;
            r_next_addr <= (r_next_addr == LAST_ADDR) ? '0 : r_next_addr + 1'b1;
          end
        end
        S_DISCARD: begin
          r_bit_cnt <= '0;
        end
        default: r_state <= S_DISCARD;
      endcase
    end
  end

endmodule

// File: doc/spi_pixel_slave.md
# spi_pixel_slave

Parametrised, framed SPI receiver that turns a host byte stream into addressed pixel writes for the HUB75 framebuffer. It sits between the host SPI pins and the framebuffer write port, and it generalises the plain shift-and-strobe SPI slave. Each transaction is framed by a chip select and carries a command, an explicit start address, and auto-incrementing, wrapping pixel words. It also supports a buffer-flip command, and an optional MISO status readback.

## Interface
Parameters:
- BITS_PER_PIXEL, 32, pixel word width (≥8).
- PIXEL_COUNT, 2048, framebuffer depth in pixels; localparam ADDR_BITS = $clog2(PIXEL_COUNT).

Ports:
- spi_clk  input  1  sole clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high.
- spi_ss_n  input  1  chip select, active-low, sampled on posedge spi_clk.
- spi_mosi  input  1  serial data, MSB first, sampled on posedge spi_clk.
- spi_miso  output  1  status readback (see Configuration).
- data  output  BITS_PER_PIXEL  last complete pixel word.
- addr  output  ADDR_BITS  framebuffer address of `data`.
- pixel_clk  output  1  write strobe, high one spi_clk cycle per pixel.
- flip  output  1  buffer-swap pulse, high one spi_clk cycle.

## Operation
- Frame format, with spi_ss_n low throughout:
  - 8-bit command.
  - Then, for WRITE only, a 16-bit start address.
  - Then pixel words of BITS_PER_PIXEL bits each.
- States:
  - CMD: shift 8 bits.
    - 0x01 → ADDR.
    - 0x02 → assert flip, increment 8-bit frame_count (wraps 255→0), → DISCARD.
    - Any other value → DISCARD.
  - ADDR: shift 16 bits.
    - Load next_addr with the low ADDR_BITS bits.
    - If the 16-bit value ≥ PIXEL_COUNT, load 0.
    - → PIXELS.
  - PIXELS: shift BITS_PER_PIXEL bits. On the last bit:
    - data ← completed word.
    - addr ← next_addr.
    - pixel_clk ← 1.
    - next_addr ← next_addr+1, wrapping PIXEL_COUNT-1 → 0.
    - Bit counter restarts; remain in PIXELS.
  - DISCARD: ignore mosi until spi_ss_n is high.
- spi_ss_n high at any posedge:
  - State → CMD, bit counter → 0, shift register cleared.
  - A partially received word or address is dropped.
  - No pixel_clk or flip is produced on that edge, even if it would have completed a word (ss_n has priority).
- data and addr hold their values until the next completed pixel.
- next_addr is internal; it is not visible on addr until the next strobe.

## Timing
- Reset values:
  - Outputs: data=0, addr=0, pixel_clk=0, flip=0, spi_miso=0.
  - Internal: state=CMD, frame_count=0, next_addr=0.
- Reset mid-transaction aborts immediately. The next frame must start with a command, with spi_ss_n low after reset deasserts.
- Strobe timing:
  - pixel_clk rises on the same posedge that samples a word's last bit; data and addr are updated on that edge.
  - pixel_clk falls on the following posedge.
  - Consumers latch on posedge pixel_clk; data and addr are stable for ≥BITS_PER_PIXEL-1 further cycles.
- flip rises on the posedge that samples the 8th command bit, and falls on the next posedge.
- Latency, from first mosi bit of a WRITE frame:
  - First pixel_clk rises on edge 24+BITS_PER_PIXEL.
  - Subsequent pixel_clk rises every BITS_PER_PIXEL edges.
- No back-pressure: the consumer must accept one write per BITS_PER_PIXEL spi_clk cycles.

## Configuration
- SPI_STATUS_READBACK_EN defined:
  - During the CMD state, spi_miso drives frame_count MSB first.
  - Each bit updates on the posedge that samples the corresponding command bit; bit 7 appears on the first edge with spi_ss_n low.
  - The host samples on negedge.
  - spi_miso = 0 in all other states.
- Not defined: spi_miso tied to 0 and frame_count omitted; flip behaviour is unchanged.

## Test plan
- WRITE, addr 0x0005, pixels 0xdeadbeef, 0xcabba6e0 → two pixel_clk pulses 32 cycles apart with (data, addr) = (deadbeef, 5), then (cabba6e0, 6); pixel_clk high exactly one cycle each.
- WRITE, addr 0x07FF, three pixels (PIXEL_COUNT=2048) → addr 2047, 0, 1. Separately, addr 0x9000 → first addr 0.
- WRITE, one full pixel then 20 bits of a second, then spi_ss_n high → exactly one strobe. A following WRITE to addr 0x0010 with 0x00000000 strobes addr 0x10 correctly.
- Command 0x02 → flip high one cycle, no pixel_clk. Command 0x55 followed by 64 arbitrary bits → no strobes. With SPI_STATUS_READBACK_EN, the next frame's spi_miso reads 0x01.
- Assert reset after 10 bits of a pixel → all outputs 0 asynchronously. A fresh WRITE after reset delivers the correct first pixel at its start addr.
- spi_ss_n raised on the edge sampling a word's last bit → no pixel_clk, addr unchanged.
